// File: rtl/mem_pkg.sv
// Shared constants and types for the two-port memory arbiter.
package mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    // Busy state that serves the given port index.
    function automatic arb_state_t busy_state(input logic port);
        return (port == PORT_I) ? BUSY1 : BUSY0;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone requester always wins, a tie goes to
// the port that was not granted last.
module rr_pick2
    import mem_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_grant_valid,
    output logic o_grant_idx
);

    // Pick the winner for the current request pair.
    always_comb begin
        o_grant_valid = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_grant_idx = ~i_last_grant;
        end else if (i_req1) begin
            o_grant_idx = PORT_I;
        end else begin
            o_grant_idx = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single line-wide memory port between the dcache (port 0) and
// the icache (port 1). One whole line transaction at a time, alternating
// priority on ties, with a watchdog for transactions that are never acked.
//
//   state | meaning
//   IDLE  | no transaction; next grant decided here
//   BUSY0 | serving dcache, waiting for mem_ack_i
//   BUSY1 | serving icache, waiting for mem_ack_i
module mem_arbiter #(
    parameter int ADDR_W  = mem_pkg::ADDR_W,
    parameter int DATA_W  = mem_pkg::DATA_W,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_enable_i,
    input  logic              req0_write_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ack_o,
    output logic [DATA_W-1:0] req0_data_o,

    input  logic              req1_enable_i,
    input  logic              req1_write_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ack_o,
    output logic [DATA_W-1:0] req1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,

    output logic              busy_o,
    output logic              timeout_o
);
    import mem_pkg::*;

    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    // Timer value on the last permitted busy cycle without an ack.
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    arb_state_t          r_state;
    logic                r_last_grant;
    logic [TIMER_W-1:0]  r_timer;
    logic                r_timeout;
    logic                r_mem_enable;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_data;

    logic                w_grant_valid;
    logic                w_grant_idx;
    logic                w_busy;
    logic                w_ack0;
    logic                w_ack1;
    logic                w_expire;

    rr_pick2 u_pick (
        .i_req0        (req0_enable_i),
        .i_req1        (req1_enable_i),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    assign w_busy   = (r_state != IDLE);
    // An ack seen while reset is asserted belongs to a transaction being
    // abandoned, so it is not forwarded.
    assign w_ack0   = rst_i & mem_ack_i & (r_state == BUSY0);
    assign w_ack1   = rst_i & mem_ack_i & (r_state == BUSY1);
    assign w_expire = w_busy & ~mem_ack_i & (r_timer == TIMER_LAST);

    // Arbitration FSM; the captured request doubles as the registered memory drive.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state      <= IDLE;
            r_last_grant <= PORT_I;
            r_timer      <= '0;
            r_timeout    <= 1'b0;
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_state      <= busy_state(w_grant_idx);
                        r_last_grant <= w_grant_idx;
                        r_timer      <= '0;
                        r_mem_enable <= 1'b1;
                        r_mem_write  <= (w_grant_idx == PORT_I) ? req1_write_i : req0_write_i;
                        r_mem_addr   <= (w_grant_idx == PORT_I) ? req1_addr_i  : req0_addr_i;
                        r_mem_data   <= (w_grant_idx == PORT_I) ? req1_data_i  : req0_data_i;
                    end
                end
                BUSY0, BUSY1: begin
                    if (mem_ack_i || w_expire) begin
                        r_state      <= IDLE;
                        r_mem_enable <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_mem_addr   <= '0;
                        r_mem_data   <= '0;
                        if (w_expire) begin
                            r_timeout <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_mem_enable <= 1'b0;
                    r_mem_write  <= 1'b0;
                    r_mem_addr   <= '0;
                    r_mem_data   <= '0;
                end
            endcase
        end
    end

    assign mem_enable_o = r_mem_enable;
    assign mem_write_o  = r_mem_write;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;

    assign req0_ack_o   = w_ack0;
    assign req1_ack_o   = w_ack1;
    assign req0_data_o  = w_ack0 ? mem_data_i : '0;
    assign req1_data_o  = w_ack1 ? mem_data_i : '0;

    assign busy_o       = w_busy;
    assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run, all
// checked cycle by cycle against a transaction-level reference and a golden
// line store.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 256;
    localparam int TO = 15;
    typedef logic [DW-1:0] line_t;

    localparam line_t PAT1 = 256'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1111_2222_3333_4444_5555_6666_7777_0000;
    localparam line_t WPAT = 256'h1001_2002_3003_4004_5005_6006_7007_8008_9009_A00A_B00B_C00C_D00D_E00E_F00F_0110;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          req0_enable_i = 1'b0, req0_write_i = 1'b0;
    logic [AW-1:0] req0_addr_i = '0;
    line_t         req0_data_i = '0;
    logic          req1_enable_i = 1'b0, req1_write_i = 1'b0;
    logic [AW-1:0] req1_addr_i = '0;
    line_t         req1_data_i = '0;
    logic          req0_ack_o, req1_ack_o;
    line_t         req0_data_o, req1_data_o;
    logic          mem_enable_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;
    line_t         mem_data_o;
    logic          mem_ack_i = 1'b0;
    line_t         mem_data_i = '0;
    logic          busy_o, timeout_o;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_enable_i(req0_enable_i), .req0_write_i(req0_write_i),
        .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
        .req0_ack_o(req0_ack_o), .req0_data_o(req0_data_o),
        .req1_enable_i(req1_enable_i), .req1_write_i(req1_write_i),
        .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
        .req1_ack_o(req1_ack_o), .req1_data_o(req1_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input line_t act, input line_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // requester agents
    logic          pend[2]  = '{1'b0, 1'b0};
    logic          wr[2]    = '{1'b0, 1'b0};
    logic [AW-1:0] adr[2]   = '{32'h0, 32'h0};
    line_t         dat[2]   = '{'0, '0};
    bit            auto_req = 0, hold_req = 0, scramble = 0, do_rst = 1;
    // memory agent
    int            fixed_lat = -1;
    bit            mem_stall = 0, stray_ack = 0, mem_run = 0;
    int            mem_wait = 0;
    line_t         mem_arr[logic [AW-1:0]];
    line_t         gold[logic [AW-1:0]];
    // reference
    bit            m_busy = 0, m_to = 0;
    int            m_port = 0, m_last = 1, m_cnt = 0;
    logic          m_wr = 1'b0;
    logic [AW-1:0] m_adr = '0;
    line_t         m_dat = '0;
    // observations
    logic          seen_ack[2] = '{1'b0, 1'b0};
    line_t         last_rd[2]  = '{'0, '0};
    int            ack_cnt[2]  = '{0, 0};
    int            ack_order[$];
    logic [AW-1:0] grant_addrs[$];
    int            en_cycles = 0, busy_cycles = 0, to_busy = 0;
    bit            to_seen = 0, prev_en = 0;

    function automatic line_t init_line(input logic [AW-1:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    function automatic line_t mem_rd(input logic [AW-1:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : init_line(a);
    endfunction

    function automatic line_t gold_rd(input logic [AW-1:0] a);
        return gold.exists(a) ? gold[a] : init_line(a);
    endfunction

    function automatic int order_at(input int idx);
        return (idx < ack_order.size()) ? ack_order[idx] : -1;
    endfunction

    function automatic logic [AW-1:0] gaddr_at(input int idx);
        return (idx < grant_addrs.size()) ? grant_addrs[idx] : 32'hFFFF_FFFF;
    endfunction

    task automatic drive_inputs();
        logic nack;
        nack = 1'b0;
        for (int n = 0; n < 2; n++) begin
            if (seen_ack[n] && !hold_req) pend[n] = 1'b0;
            if (auto_req && !pend[n] && !(m_busy && m_port == n) && $urandom_range(0, 3) == 0) begin
                pend[n] = 1'b1;
                wr[n]   = 1'($urandom_range(0, 1));
                adr[n]  = {24'h0, 3'($urandom_range(0, 7)), 5'h0};
                dat[n]  = {8{$urandom}};
            end else if (auto_req && pend[n] && $urandom_range(0, 99) == 0) begin
                pend[n] = 1'b0;
            end else if (scramble && pend[n] && m_busy && m_port == n) begin
                wr[n]  = 1'($urandom_range(0, 1));
                adr[n] = $urandom;
                dat[n] = {8{$urandom}};
            end
        end
        rst_i         = ~do_rst;
        req0_enable_i = pend[0];
        req0_write_i  = pend[0] ? wr[0]  : 1'($urandom_range(0, 1));
        req0_addr_i   = pend[0] ? adr[0] : $urandom;
        req0_data_i   = pend[0] ? dat[0] : {8{$urandom}};
        req1_enable_i = pend[1];
        req1_write_i  = pend[1] ? wr[1]  : 1'($urandom_range(0, 1));
        req1_addr_i   = pend[1] ? adr[1] : $urandom;
        req1_data_i   = pend[1] ? dat[1] : {8{$urandom}};

        if (stray_ack) begin
            nack = 1'b1;
            stray_ack = 0;
            mem_run = 0;
        end else if (!mem_enable_o) begin
            mem_run = 0;
        end else if (!mem_stall) begin
            if (!mem_run) begin
                mem_run  = 1;
                mem_wait = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 6));
            end
            if (mem_wait == 0) begin
                nack = 1'b1;
                mem_run = 0;
            end else begin
                mem_wait--;
            end
        end
        if (nack) begin
            if (mem_enable_o && mem_write_o) mem_arr[mem_addr_o] = mem_data_o;
            mem_data_i = mem_rd(mem_addr_o);
        end else begin
            mem_data_i = {8{$urandom}};
        end
        mem_ack_i = nack;
    endtask

    task automatic check_outputs();
        logic e_ack0, e_ack1;
        e_ack0 = m_busy && m_port == 0 && mem_ack_i && rst_i;
        e_ack1 = m_busy && m_port == 1 && mem_ack_i && rst_i;
        chk_eq("mem_enable", line_t'(mem_enable_o), line_t'(m_busy));
        chk_eq("mem_write",  line_t'(mem_write_o),  line_t'(m_busy ? m_wr : 1'b0));
        chk_eq("mem_addr",   line_t'(mem_addr_o),   line_t'(m_busy ? m_adr : 32'h0));
        chk_eq("mem_data",   mem_data_o,            m_busy ? m_dat : '0);
        chk_eq("busy",       line_t'(busy_o),       line_t'(m_busy));
        chk_eq("timeout",    line_t'(timeout_o),    line_t'(m_to));
        chk_eq("ack0",       line_t'(req0_ack_o),   line_t'(e_ack0));
        chk_eq("ack1",       line_t'(req1_ack_o),   line_t'(e_ack1));
        chk_eq("data0",      req0_data_o,           e_ack0 ? mem_data_i : '0);
        chk_eq("data1",      req1_data_o,           e_ack1 ? mem_data_i : '0);
        if ((e_ack0 || e_ack1) && !m_wr)
            chk_eq("rd_vs_written", e_ack0 ? req0_data_o : req1_data_o, gold_rd(m_adr));
    endtask

    task automatic observe();
        seen_ack[0] = req0_ack_o;
        seen_ack[1] = req1_ack_o;
        if (req0_ack_o) begin ack_cnt[0]++; last_rd[0] = req0_data_o; ack_order.push_back(0); end
        if (req1_ack_o) begin ack_cnt[1]++; last_rd[1] = req1_data_o; ack_order.push_back(1); end
        if (mem_enable_o) en_cycles++;
        if (mem_enable_o && !prev_en) grant_addrs.push_back(mem_addr_o);
        prev_en = mem_enable_o;
        if (busy_o) busy_cycles++;
        if (timeout_o && !to_seen) begin to_seen = 1; to_busy = busy_cycles; end
    endtask

    // One clock edge of the arbiter as described behaviourally.
    task automatic model_update();
        if (!rst_i) begin
            m_busy = 0; m_last = 1; m_cnt = 0; m_to = 0;
        end else if (!m_busy) begin
            if (req0_enable_i || req1_enable_i) begin
                if (req0_enable_i && req1_enable_i) m_port = 1 - m_last;
                else m_port = req1_enable_i ? 1 : 0;
                m_last = m_port;
                m_busy = 1;
                m_cnt  = 0;
                m_wr   = m_port ? req1_write_i : req0_write_i;
                m_adr  = m_port ? req1_addr_i  : req0_addr_i;
                m_dat  = m_port ? req1_data_i  : req0_data_i;
            end
        end else if (mem_ack_i) begin
            if (m_wr) gold[m_adr] = m_dat;
            m_busy = 0;
        end else begin
            m_cnt++;
            if (m_cnt == TO) begin m_to = 1; m_busy = 0; end
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        drive_inputs();
        #1;
        check_outputs();
        observe();
        model_update();
    endtask

    task automatic clear_obs();
        ack_cnt[0] = 0; ack_cnt[1] = 0;
        ack_order.delete();
        grant_addrs.delete();
        en_cycles = 0; busy_cycles = 0; to_busy = 0; to_seen = 0;
    endtask

    task automatic do_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        do_rst = 1; step(); step(); do_rst = 0;
        clear_obs();
    endtask

    initial begin
        #1ms;
        $display("FAIL global_time_limit: got expired, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (3) step();
        do_rst = 0;
        step();
        chk_eq("rst_busy_idle", line_t'(busy_o), line_t'(1'b0));
        clear_obs();

        // single dcache read, 10-cycle memory latency
        mem_arr[32'h20] = PAT1; gold[32'h20] = PAT1;
        fixed_lat = 10;
        pend[0] = 1'b1; wr[0] = 1'b0; adr[0] = 32'h20; dat[0] = '0;
        for (int k = 0; k < 60 && ack_cnt[0] == 0; k++) step();
        repeat (3) step();
        chk_eq("t1_en_cycles", line_t'(en_cycles), line_t'(11));
        chk_eq("t1_ack0_cnt",  line_t'(ack_cnt[0]), line_t'(1));
        chk_eq("t1_ack1_cnt",  line_t'(ack_cnt[1]), line_t'(0));
        chk_eq("t1_rd_data",   last_rd[0], PAT1);

        // simultaneous requests right after reset
        do_reset();
        fixed_lat = 2;
        pend[0] = 1'b1; wr[0] = 1'b0; adr[0] = 32'h0;
        pend[1] = 1'b1; wr[1] = 1'b0; adr[1] = 32'h40;
        for (int k = 0; k < 60 && ack_cnt[1] == 0; k++) step();
        step();
        chk_eq("t2_grant_cnt", line_t'(grant_addrs.size()), line_t'(2));
        chk_eq("t2_addr_first",  line_t'(gaddr_at(0)), line_t'(32'h0));
        chk_eq("t2_addr_second", line_t'(gaddr_at(1)), line_t'(32'h40));
        chk_eq("t2_order_first", line_t'(order_at(0)), line_t'(0));

        // both held continuously: strict alternation
        do_reset();
        fixed_lat = -1; hold_req = 1;
        pend[0] = 1'b1; wr[0] = 1'b0; adr[0] = 32'h60;
        pend[1] = 1'b1; wr[1] = 1'b0; adr[1] = 32'hA0;
        for (int k = 0; k < 100 && ack_order.size() < 4; k++) step();
        pend[0] = 1'b0; pend[1] = 1'b0; hold_req = 0;
        step(); step();
        for (int i = 0; i < 4; i++)
            chk_eq($sformatf("t3_order_%0d", i), line_t'(order_at(i)), line_t'(i % 2));

        // write a line from dcache, read it back via icache
        do_reset();
        pend[0] = 1'b1; wr[0] = 1'b1; adr[0] = 32'h400; dat[0] = WPAT;
        for (int k = 0; k < 60 && ack_cnt[0] == 0; k++) step();
        pend[1] = 1'b1; wr[1] = 1'b0; adr[1] = 32'h400;
        for (int k = 0; k < 60 && ack_cnt[1] == 0; k++) step();
        step();
        chk_eq("t4_readback", last_rd[1], WPAT);

        // memory never acks: watchdog
        do_reset();
        mem_stall = 1;
        pend[0] = 1'b1; wr[0] = 1'b0; adr[0] = 32'h80;
        for (int k = 0; k < 40 && !to_seen; k++) step();
        pend[0] = 1'b0;
        chk_eq("t5_timeout_seen",  line_t'(to_seen), line_t'(1));
        chk_eq("t5_busy_cycles",   line_t'(to_busy), line_t'(TO));
        repeat (20) step();
        chk_eq("t5_timeout_sticky", line_t'(timeout_o), line_t'(1'b1));
        chk_eq("t5_no_acks", line_t'(ack_cnt[0] + ack_cnt[1]), line_t'(0));
        mem_stall = 0;

        // reset mid-transaction, then a stray ack
        do_reset();
        fixed_lat = 10;
        pend[0] = 1'b1; wr[0] = 1'b0; adr[0] = 32'hC0;
        for (int k = 0; k < 20 && busy_cycles < 3; k++) step();
        do_rst = 1; step();
        do_rst = 0; stray_ack = 1; step();
        chk_eq("t6_stray_not_fwd", line_t'(ack_cnt[0] + ack_cnt[1]), line_t'(0));
        chk_eq("t6_enable_dropped", line_t'(mem_enable_o), line_t'(1'b0));
        for (int k = 0; k < 40 && ack_cnt[0] == 0; k++) step();
        chk_eq("t6_served_after", line_t'(ack_cnt[0]), line_t'(1));

        // randomized traffic
        do_reset();
        fixed_lat = -1; auto_req = 1; scramble = 1;
        repeat (3000) step();
        auto_req = 0; scramble = 0;
        for (int k = 0; k < 40 && (pend[0] || pend[1] || m_busy); k++) step();
        chk_eq("rand_drained", line_t'(busy_o), line_t'(1'b0));
        chk_eq("rand_no_timeout", line_t'(timeout_o), line_t'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
